// File: rtl/npc_io_periph.sv
// Board I/O block: running-light LEDs mixed with switches, PS/2 scan-code receiver
// with FIFO, and 640x480@60 VGA timing with pass-through of externally looked-up RGB.
module npc_io_periph #(
    parameter int unsigned LED_PERIOD = 5_000_000,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  sw,
    output logic [15:0] ledr,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        kbd_nextdata_n,
    output logic [7:0]  kbd_data,
    output logic        kbd_ready,
    output logic        kbd_overflow,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int unsigned CNT_W   = $clog2(LED_PERIOD);
    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_START = 144;
    localparam int unsigned H_END   = 784;
    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_START = 35;
    localparam int unsigned V_END   = 515;
    localparam int unsigned V_TOTAL = 525;

    // ---------------- LED running light ----------------
    logic [7:0]       rot;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rot <= 8'h01;
            cnt <= '0;
        end else if (cnt == CNT_W'(LED_PERIOD - 1)) begin
            cnt <= '0;
            rot <= {rot[6:0], rot[7]};
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign ledr = {rot, sw};

    // ---------------- PS/2 receiver ----------------
    logic [2:0]         ps2_sync;
    logic [9:0]         buffer;
    logic [3:0]         count;
    logic [FIFO_AW-1:0] w_ptr;
    logic [FIFO_AW-1:0] r_ptr;
    logic [7:0]         fifo [DEPTH];
    logic               fall;
    logic               frame_end;
    logic               frame_ok;
    logic               full;
    logic               push;
    logic               pop;

    always_comb begin
        fall      = ps2_sync[2] & ~ps2_sync[1];
        frame_end = fall && (count == 4'd10);
        frame_ok  = ~buffer[0] & ps2_data & (^buffer[9:1]);
        full      = (w_ptr + FIFO_AW'(1)) == r_ptr;
        push      = frame_end & frame_ok & ~full;
        pop       = ~kbd_nextdata_n & kbd_ready;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ps2_sync     <= '0;
            buffer       <= '0;
            count        <= '0;
            w_ptr        <= '0;
            r_ptr        <= '0;
            kbd_overflow <= 1'b0;
        end else begin
            ps2_sync <= {ps2_sync[1:0], ps2_clk};
            if (fall) begin
                if (count == 4'd10) begin
                    count <= '0;
                    if (frame_ok && full)
                        kbd_overflow <= 1'b1;
                end else begin
                    buffer[count] <= ps2_data;
                    count         <= count + 4'd1;
                end
            end
            if (push)
                w_ptr <= w_ptr + FIFO_AW'(1);
            if (pop)
                r_ptr <= r_ptr + FIFO_AW'(1);
        end
    end

    // Storage needs no reset: contents are only observed behind kbd_ready.
    always_ff @(posedge clk) begin
        if (push)
            fifo[w_ptr] <= buffer[8:1];
    end

    assign kbd_ready = (w_ptr != r_ptr);
    assign kbd_data  = fifo[r_ptr];

    // ---------------- VGA timing ----------------
    logic [9:0] x;
    logic [9:0] y;
    logic       h_valid;
    logic       v_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x <= '0;
            y <= '0;
        end else if (x == 10'(H_TOTAL - 1)) begin
            x <= '0;
            y <= (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
        end else begin
            x <= x + 10'd1;
        end
    end

    always_comb begin
        hsync   = (x >= 10'(H_SYNC));
        vsync   = (y >= 10'(V_SYNC));
        h_valid = (x >= 10'(H_START)) && (x < 10'(H_END));
        v_valid = (y >= 10'(V_START)) && (y < 10'(V_END));
        valid   = h_valid & v_valid;
        h_addr  = h_valid ? x - 10'(H_START) : 10'd0;
        v_addr  = v_valid ? y - 10'(V_START) : 10'd0;
        vga_r   = valid ? vga_data[23:16] : 8'd0;
        vga_g   = valid ? vga_data[15:8]  : 8'd0;
        vga_b   = valid ? vga_data[7:0]   : 8'd0;
    end

endmodule

// File: tb/tb_npc_io_periph.sv
// Directed bench for npc_io_periph: LED rotation, PS/2 framing/FIFO/overflow, VGA timing.
module tb_npc_io_periph;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  sw;
    logic [15:0] ledr;
    logic        ps2_clk;
    logic        ps2_data;
    logic        kbd_nextdata_n;
    logic [7:0]  kbd_data;
    logic        kbd_ready;
    logic        kbd_overflow;
    logic [23:0] vga_data;
    logic [9:0]  h_addr;
    logic [9:0]  v_addr;
    logic        hsync;
    logic        vsync;
    logic        valid;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;

    int ncmp = 0;
    int nfail = 0;
    int pos = 0;

    npc_io_periph #(.LED_PERIOD(4), .FIFO_AW(3)) dut (
        .clk(clk), .resetn(resetn), .sw(sw), .ledr(ledr),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kbd_nextdata_n(kbd_nextdata_n),
        .kbd_data(kbd_data), .kbd_ready(kbd_ready), .kbd_overflow(kbd_overflow),
        .vga_data(vga_data), .h_addr(h_addr), .v_addr(v_addr),
        .hsync(hsync), .vsync(vsync), .valid(valid),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bits go out LSB first: start, 8 data, parity, stop; device samples on ps2_clk fall.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = bits[i];
            #20 ps2_clk = 1'b0;
            #50 ps2_clk = 1'b1;
            #30;
        end
        ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pop_once();
        kbd_nextdata_n = 1'b0;
        @(negedge clk);
        kbd_nextdata_n = 1'b1;
    endtask

    task automatic goto_pos(input int target);
        while (pos < target) begin
            @(negedge clk);
            pos++;
        end
    endtask

    logic [7:0] codes [8];
    int hs_low;
    int n;

    initial begin
        codes[0] = 8'h1C; codes[1] = 8'h32; codes[2] = 8'h21; codes[3] = 8'h23;
        codes[4] = 8'h24; codes[5] = 8'h2B; codes[6] = 8'h34; codes[7] = 8'h33;
        resetn = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; kbd_nextdata_n = 1'b1;
        sw = 8'hA5; vga_data = 24'h112233;
        repeat (3) @(negedge clk);

        chk("rst_ledr", 32'(ledr), 32'h01A5);
        chk("rst_ready", 32'(kbd_ready), 32'h0);
        chk("rst_ovf", 32'(kbd_overflow), 32'h0);
        chk("rst_sync", 32'({hsync, vsync, valid}), 32'h0);
        chk("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);

        // LED rotation with period 4
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("led_4clk", 32'(ledr), 32'h02A5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("led_8clk", 32'(ledr), 32'h04A5);
        repeat (24) @(posedge clk);
        @(negedge clk);
        chk("led_32clk", 32'(ledr), 32'h01A5);
        sw = 8'h3C;
        #1 chk("led_sw_comb", 32'(ledr), 32'h013C);
        @(negedge clk);

        // Single good frame then pop
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("ps2_ready", 32'(kbd_ready), 32'h1);
        chk("ps2_data", 32'(kbd_data), 32'h1C);
        pop_once();
        chk("ps2_popped", 32'(kbd_ready), 32'h0);
        pop_once();
        chk("ps2_pop_empty", 32'(kbd_ready), 32'h0);

        // Bad parity, then bad stop bit
        send_frame(8'h1C, 1'b1, 1'b1);
        chk("ps2_badpar", 32'(kbd_ready), 32'h0);
        send_frame(8'h1C, 1'b0, 1'b0);
        chk("ps2_badstop", 32'(kbd_ready), 32'h0);
        chk("ps2_bad_ovf", 32'(kbd_overflow), 32'h0);

        // Fill: 7 stored, 8th overflows
        for (int i = 0; i < 7; i++)
            send_frame(codes[i], ~^codes[i], 1'b1);
        chk("fifo_7_ovf", 32'(kbd_overflow), 32'h0);
        send_frame(codes[7], ~^codes[7], 1'b1);
        chk("fifo_8_ovf", 32'(kbd_overflow), 32'h1);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("fifo_rdy%0d", i), 32'(kbd_ready), 32'h1);
            chk($sformatf("fifo_code%0d", i), 32'(kbd_data), 32'(codes[i]));
            pop_once();
        end
        chk("fifo_drained", 32'(kbd_ready), 32'h0);
        chk("fifo_ovf_sticky", 32'(kbd_overflow), 32'h1);

        // VGA: fresh reset, pos counts clk edges since release
        resetn = 1'b0;
        @(negedge clk);
        chk("rst2_ovf", 32'(kbd_overflow), 32'h0);
        resetn = 1'b1;
        pos = 0;
        hs_low = 0;
        for (int i = 0; i < 800; i++) begin
            if (hsync == 1'b0) hs_low++;
            @(negedge clk);
            pos++;
        end
        chk("hsync_low_cnt", 32'(hs_low), 32'd96);
        goto_pos(1599);
        chk("vsync_y1", 32'(vsync), 32'h0);
        goto_pos(1600);
        chk("vsync_y2", 32'(vsync), 32'h1);
        goto_pos(34 * 800 + 300);
        chk("vga_y34_valid", 32'(valid), 32'h0);
        goto_pos(35 * 800 + 143);
        chk("vga_x143_valid", 32'(valid), 32'h0);
        chk("vga_x143_haddr", 32'(h_addr), 32'h0);
        goto_pos(35 * 800 + 144);
        chk("vga_first_valid", 32'(valid), 32'h1);
        chk("vga_first_addr", 32'({h_addr, v_addr}), 32'h0);
        chk("vga_first_rgb", 32'({vga_r, vga_g, vga_b}), 32'h112233);
        goto_pos(35 * 800 + 783);
        chk("vga_last_haddr", 32'(h_addr), 32'd639);
        chk("vga_last_valid", 32'(valid), 32'h1);
        goto_pos(35 * 800 + 784);
        chk("vga_x784_valid", 32'(valid), 32'h0);
        chk("vga_x784_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        goto_pos(36 * 800 + 300);
        chk("vga_mid_valid", 32'(valid), 32'h1);
        chk("vga_mid_haddr", 32'(h_addr), 32'd156);
        chk("vga_mid_vaddr", 32'(v_addr), 32'd1);

        // Mid-line reset at x=300
        resetn = 1'b0;
        #1;
        chk("midrst_sync", 32'({hsync, vsync, valid}), 32'h0);
        chk("midrst_addr", 32'({h_addr, v_addr}), 32'h0);
        chk("midrst_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        n = 0;
        while (hsync == 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_hsync_rise", 32'(n), 32'd96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
